// File: rtl/temp_sample_ctrl_pkg.sv
// temp_sample_ctrl_pkg: shared state encoding and constants for the temperature sampler
package temp_sample_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, LATCH, FAIL} state_t;
  localparam logic [7:0] DISP_MAX = 8'd99;
  localparam logic [7:0] F_OFFSET = 8'd32;
  localparam int SAMPLE_PERIOD_DEF = 100_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/temp_sample_ctrl_c2f.sv
// c2f_clamp: Celsius to Fahrenheit, (c*9)/5+32 at 12 bits, clamped to the display range
module c2f_clamp
  import temp_sample_ctrl_pkg::*;
(
  input  logic [7:0] c,
  output logic [7:0] f
);
  logic [11:0] w;
  assign w = ({4'd0, c} * 12'd9) / 12'd5 + {4'd0, F_OFFSET};
  assign f = (w > {4'd0, DISP_MAX}) ? DISP_MAX : w[7:0];
endmodule

// File: rtl/temp_sample_ctrl.sv
// temp_sample_ctrl: periodic/forced sensor read sequencer with latched C/F display values
// Optional REQ timeout enabled by defining TEMP_SAMPLE_TIMEOUT_EN.
module temp_sample_ctrl
  import temp_sample_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = SAMPLE_PERIOD_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       sample_now,
  output logic       rd_req,
  input  logic       rd_ack,
  input  logic       rd_err,
  input  logic [7:0] rd_data,
  output logic [7:0] disp_c,
  output logic [7:0] disp_f,
  output logic       disp_valid,
  output logic       err_flag
);
  localparam int CW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0] data, f_val;
  logic go, tmo;
  assign go = sample_now || (cnt == LAST);
  assign rd_req = (state == REQ);
`ifdef TEMP_SAMPLE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;
  assign tmo = (tcnt == TLAST);
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= (state == REQ) ? tcnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? REQ : IDLE;
      REQ:     state_nx = rd_err ? FAIL : rd_ack ? LATCH : tmo ? FAIL : REQ;
      default: state_nx = IDLE;
    endcase
  end
  c2f_clamp u_c2f (.c(data), .f(f_val));
  // rd_data is only valid with rd_ack, so it is captured then and displayed one edge later
  always_ff @(posedge clk_100MHz or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      data       <= '0;
      disp_c     <= '0;
      disp_f     <= '0;
      disp_valid <= 1'b0;
      err_flag   <= 1'b0;
    end else begin
      if (state == IDLE) cnt <= go ? '0 : cnt + 1'b1;
      if (state == REQ && rd_ack) data <= rd_data;
      if (state == LATCH) begin
        disp_c     <= (data > DISP_MAX) ? DISP_MAX : data;
        disp_f     <= f_val;
        disp_valid <= 1'b1;
        err_flag   <= 1'b0;
      end
      if (state == FAIL) err_flag <= 1'b1;
    end
endmodule
